// File: rtl/rs_alu_cluster.sv
// Reservation-station cluster feeding a single ALU pipeline with CDB wakeup.
// Entries dispatch in, wake on broadcast, issue lowest-ready-first and free on result handshake.
module rs_alu_cluster #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned N_RS     = 4,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned TAG_BASE = 1,
    parameter int unsigned LAT      = 2
) (
    input  logic              CLOCK_50,
    input  logic              RSTN_N,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [1:0]        disp_op,
    input  logic [TAG_W-1:0]  disp_tag1,
    input  logic [TAG_W-1:0]  disp_tag2,
    input  logic [DATA_W-1:0] disp_val1,
    input  logic [DATA_W-1:0] disp_val2,
    output logic [TAG_W-1:0]  disp_tag_o,
    input  logic              cdb_in_valid,
    input  logic [TAG_W-1:0]  cdb_in_tag,
    input  logic [DATA_W-1:0] cdb_in_data,
    output logic              cdb_out_valid,
    input  logic              cdb_out_ready,
    output logic [TAG_W-1:0]  cdb_out_tag,
    output logic [DATA_W-1:0] cdb_out_data,
    output logic [TAG_W-1:0]  busy_count
);
    localparam int unsigned IW = $clog2(N_RS);
    localparam int unsigned PD = LAT + 1;

    logic              busy   [N_RS];
    logic              issued [N_RS];
    logic [1:0]        op_q   [N_RS];
    logic [TAG_W-1:0]  tag1_q [N_RS];
    logic [TAG_W-1:0]  tag2_q [N_RS];
    logic [DATA_W-1:0] val1_q [N_RS];
    logic [DATA_W-1:0] val2_q [N_RS];

    logic              pv [PD];
    logic [TAG_W-1:0]  pt [PD];
    logic [DATA_W-1:0] pd [PD];

    logic              free_found, iss_found, iss_go, stall, hs, disp_go;
    logic              cdb_hit1, cdb_hit2;
    logic [IW-1:0]     free_idx, iss_idx, hs_idx;
    logic [TAG_W-1:0]  hs_rel;
    logic [DATA_W-1:0] alu_res;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        iss_found  = 1'b0;
        iss_idx    = '0;
        for (int unsigned i = 0; i < N_RS; i++) begin
            if (!free_found && !busy[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            if (!iss_found && busy[i] && !issued[i] && tag1_q[i] == '0 && tag2_q[i] == '0) begin
                iss_found = 1'b1;
                iss_idx   = IW'(i);
            end
        end
    end

    assign stall      = pv[PD-1] && !cdb_out_ready;
    assign iss_go     = iss_found && !stall;
    assign hs         = pv[PD-1] && cdb_out_ready;
    assign hs_rel     = pt[PD-1] - TAG_W'(TAG_BASE);
    assign hs_idx     = IW'(hs_rel);
    assign disp_ready = free_found;
    assign disp_go    = disp_valid && free_found;
    assign disp_tag_o = free_found ? TAG_W'(TAG_BASE) + TAG_W'(free_idx) : '0;
    assign cdb_hit1   = cdb_in_valid && cdb_in_tag != '0 && cdb_in_tag == disp_tag1;
    assign cdb_hit2   = cdb_in_valid && cdb_in_tag != '0 && cdb_in_tag == disp_tag2;

    always_comb begin
        unique case (op_q[iss_idx])
            2'b00:   alu_res = val1_q[iss_idx] + val2_q[iss_idx];
            2'b01:   alu_res = val1_q[iss_idx] - val2_q[iss_idx];
            2'b10:   alu_res = val1_q[iss_idx] & val2_q[iss_idx];
            default: alu_res = val1_q[iss_idx] ^ val2_q[iss_idx];
        endcase
    end

    assign cdb_out_valid = pv[PD-1];
    assign cdb_out_tag   = pt[PD-1];
    assign cdb_out_data  = pd[PD-1];

    always_ff @(posedge CLOCK_50) begin
        if (RSTN_N) begin
            for (int unsigned i = 0; i < N_RS; i++) begin
                busy[i]   <= 1'b0;
                issued[i] <= 1'b0;
                op_q[i]   <= '0;
                tag1_q[i] <= '0;
                tag2_q[i] <= '0;
                val1_q[i] <= '0;
                val2_q[i] <= '0;
            end
            for (int unsigned s = 0; s < PD; s++) begin
                pv[s] <= 1'b0;
                pt[s] <= '0;
                pd[s] <= '0;
            end
            busy_count <= '0;
        end else begin
            // Dispatch targets a free entry and free hits an issued one, so they never collide.
            for (int unsigned i = 0; i < N_RS; i++) begin
                if (busy[i] && cdb_in_valid && cdb_in_tag != '0) begin
                    if (tag1_q[i] == cdb_in_tag) begin
                        tag1_q[i] <= '0;
                        val1_q[i] <= cdb_in_data;
                    end
                    if (tag2_q[i] == cdb_in_tag) begin
                        tag2_q[i] <= '0;
                        val2_q[i] <= cdb_in_data;
                    end
                end
                if (iss_go && iss_idx == IW'(i))
                    issued[i] <= 1'b1;
                if (hs && hs_idx == IW'(i)) begin
                    busy[i]   <= 1'b0;
                    issued[i] <= 1'b0;
                end
                if (disp_go && free_idx == IW'(i)) begin
                    busy[i]   <= 1'b1;
                    issued[i] <= 1'b0;
                    op_q[i]   <= disp_op;
                    tag1_q[i] <= cdb_hit1 ? '0 : disp_tag1;
                    tag2_q[i] <= cdb_hit2 ? '0 : disp_tag2;
                    val1_q[i] <= cdb_hit1 ? cdb_in_data : disp_val1;
                    val2_q[i] <= cdb_hit2 ? cdb_in_data : disp_val2;
                end
            end
            // Whole pipe advances in lockstep; bubbles are kept so latency stays fixed.
            if (!stall) begin
                pv[0] <= iss_go;
                pt[0] <= iss_go ? TAG_W'(TAG_BASE) + TAG_W'(iss_idx) : '0;
                pd[0] <= iss_go ? alu_res : '0;
                for (int unsigned s = 1; s < PD; s++) begin
                    pv[s] <= pv[s-1];
                    pt[s] <= pt[s-1];
                    pd[s] <= pd[s-1];
                end
            end
            case ({disp_go, hs})
                2'b10:   busy_count <= busy_count + 1'b1;
                2'b01:   busy_count <= busy_count - 1'b1;
                default: busy_count <= busy_count;
            endcase
        end
    end
endmodule

// File: tb/tb_rs_alu_cluster.sv
// Directed self-checking bench for rs_alu_cluster with default parameters (LAT=2, N_RS=4, TAG_BASE=1).
module tb_rs_alu_cluster;
    logic        CLOCK_50 = 1'b0;
    logic        RSTN_N;
    logic        disp_valid;
    logic        disp_ready;
    logic [1:0]  disp_op;
    logic [3:0]  disp_tag1, disp_tag2;
    logic [31:0] disp_val1, disp_val2;
    logic [3:0]  disp_tag_o;
    logic        cdb_in_valid;
    logic [3:0]  cdb_in_tag;
    logic [31:0] cdb_in_data;
    logic        cdb_out_valid;
    logic        cdb_out_ready;
    logic [3:0]  cdb_out_tag;
    logic [31:0] cdb_out_data;
    logic [3:0]  busy_count;

    int n_cmp = 0;
    int n_bad = 0;

    rs_alu_cluster #(.DATA_W(32), .N_RS(4), .TAG_W(4), .TAG_BASE(1), .LAT(2)) dut (
        .CLOCK_50(CLOCK_50), .RSTN_N(RSTN_N),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_tag1(disp_tag1), .disp_tag2(disp_tag2),
        .disp_val1(disp_val1), .disp_val2(disp_val2), .disp_tag_o(disp_tag_o),
        .cdb_in_valid(cdb_in_valid), .cdb_in_tag(cdb_in_tag), .cdb_in_data(cdb_in_data),
        .cdb_out_valid(cdb_out_valid), .cdb_out_ready(cdb_out_ready),
        .cdb_out_tag(cdb_out_tag), .cdb_out_data(cdb_out_data),
        .busy_count(busy_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic disp(input logic [1:0] op, input logic [3:0] t1, input logic [31:0] v1,
                        input logic [3:0] t2, input logic [31:0] v2);
        disp_valid = 1'b1;
        disp_op    = op;
        disp_tag1  = t1;
        disp_val1  = v1;
        disp_tag2  = t2;
        disp_val2  = v2;
    endtask

    task automatic out_chk(input string tag, input logic v, input logic [3:0] t, input logic [31:0] d);
        chk({tag, ".valid"}, cdb_out_valid, v);
        chk({tag, ".tag"}, cdb_out_tag, t);
        chk({tag, ".data"}, cdb_out_data, d);
    endtask

    initial begin
        RSTN_N = 1'b1; disp_valid = 1'b0; disp_op = 2'b00;
        disp_tag1 = '0; disp_tag2 = '0; disp_val1 = '0; disp_val2 = '0;
        cdb_in_valid = 1'b0; cdb_in_tag = '0; cdb_in_data = '0; cdb_out_ready = 1'b1;
        step(); step();
        RSTN_N = 1'b0;

        chk("rst.disp_ready", disp_ready, 1'b1);
        chk("rst.disp_tag_o", disp_tag_o, 4'd1);
        out_chk("rst.out", 1'b0, 4'd0, 32'd0);
        chk("rst.busy", busy_count, 4'd0);

        // add 5+7, result 1+LAT edges after dispatch
        disp(2'b00, 4'd0, 32'd5, 4'd0, 32'd7);
        step(); disp_valid = 1'b0;
        chk("add.busy", busy_count, 4'd1);
        chk("add.tag_next", disp_tag_o, 4'd2);
        step(); chk("add.e1.valid", cdb_out_valid, 1'b0);
        step(); chk("add.e2.valid", cdb_out_valid, 1'b0);
        step(); out_chk("add.e3", 1'b1, 4'd1, 32'd12);
        chk("add.e3.busy", busy_count, 4'd1);
        step(); chk("add.freed.busy", busy_count, 4'd0);
        chk("add.freed.valid", cdb_out_valid, 1'b0);

        // sub waiting on tag 9, woken four cycles later with 10
        disp(2'b01, 4'd9, 32'd0, 4'd0, 32'd3);
        step(); disp_valid = 1'b0;
        step(); step(); step();
        cdb_in_valid = 1'b1; cdb_in_tag = 4'd9; cdb_in_data = 32'd10;
        step(); cdb_in_valid = 1'b0; cdb_in_tag = '0; cdb_in_data = '0;
        chk("sub.wait.valid", cdb_out_valid, 1'b0);
        step(); step(); step();
        out_chk("sub.wake", 1'b1, 4'd1, 32'd7);
        step();
        disp(2'b01, 4'd0, 32'd0, 4'd0, 32'd1);
        step(); disp_valid = 1'b0;
        step(); step(); step();
        out_chk("sub.wrap", 1'b1, 4'd1, 32'hFFFF_FFFF);
        step();

        // fill all entries while the output is stalled
        cdb_out_ready = 1'b0;
        disp(2'b00, 4'd0, 32'd3, 4'd0, 32'd4);           step();
        chk("fill.tag2", disp_tag_o, 4'd2);
        disp(2'b10, 4'd0, 32'hF0F0, 4'd0, 32'h0FF0);     step();
        chk("fill.tag3", disp_tag_o, 4'd3);
        disp(2'b11, 4'd0, 32'hA5, 4'd0, 32'hFF);         step();
        chk("fill.tag4", disp_tag_o, 4'd4);
        disp(2'b00, 4'd0, 32'hFFFF_FFFF, 4'd0, 32'd2);   step();
        chk("full.ready", disp_ready, 1'b0);
        chk("full.busy", busy_count, 4'd4);
        chk("full.tag_o", disp_tag_o, 4'd0);
        // extra dispatch held high through the stall and the freeing edge
        disp(2'b00, 4'd0, 32'd100, 4'd0, 32'd100);
        for (int i = 0; i < 5; i++) begin
            step();
            out_chk("stall.hold", 1'b1, 4'd1, 32'd7);
            chk("stall.busy", busy_count, 4'd4);
        end
        cdb_out_ready = 1'b1;
        step(); disp_valid = 1'b0;
        chk("drain1.ready", disp_ready, 1'b1);
        chk("drain1.busy", busy_count, 4'd3);
        chk("drain1.tag_o", disp_tag_o, 4'd1);
        out_chk("drain1", 1'b1, 4'd2, 32'h0000_00F0);
        step(); out_chk("drain2", 1'b1, 4'd3, 32'h0000_005A);
        chk("drain2.busy", busy_count, 4'd2);
        step(); out_chk("drain3", 1'b1, 4'd4, 32'd1);
        step(); chk("drain.empty.valid", cdb_out_valid, 1'b0);
        chk("drain.empty.busy", busy_count, 4'd0);

        // same-cycle capture of operand 2 from the broadcast bus
        disp(2'b00, 4'd0, 32'h10, 4'd6, 32'hDEAD);
        cdb_in_valid = 1'b1; cdb_in_tag = 4'd6; cdb_in_data = 32'h55;
        step(); disp_valid = 1'b0; cdb_in_valid = 1'b0; cdb_in_tag = '0;
        step(); step(); step();
        out_chk("bypass", 1'b1, 4'd1, 32'h65);
        step();

        // reset with three busy entries and a full pipeline
        cdb_out_ready = 1'b0;
        disp(2'b00, 4'd0, 32'd1, 4'd0, 32'd1); step();
        disp(2'b00, 4'd0, 32'd2, 4'd0, 32'd2); step();
        disp(2'b00, 4'd0, 32'd3, 4'd0, 32'd3); step();
        disp_valid = 1'b0;
        step();
        chk("pre.busy", busy_count, 4'd3);
        chk("pre.valid", cdb_out_valid, 1'b1);
        RSTN_N = 1'b1;
        step();
        RSTN_N = 1'b0; cdb_out_ready = 1'b1;
        chk("midrst.disp_ready", disp_ready, 1'b1);
        chk("midrst.disp_tag_o", disp_tag_o, 4'd1);
        out_chk("midrst.out", 1'b0, 4'd0, 32'd0);
        chk("midrst.busy", busy_count, 4'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("postrst.no_stale", cdb_out_valid, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rs_alu_cluster.md
RS_ALU_CLUSTER -- requirements
Module: rs_alu_cluster

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand/result width.
REQ-002 SHALL have parameter N_RS, default 4: reservation-station entries (2..15).
REQ-003 SHALL have parameter TAG_W, default 4: tag width; tag 0 = "value ready".
REQ-004 SHALL have parameter TAG_BASE, default 1: entry i owns tag TAG_BASE+i; TAG_BASE>=1.
REQ-005 SHALL have parameter LAT, default 2: execute pipeline depth (1..4).
REQ-006 SHALL have port CLOCK_50  in  1  sole clock, rising edge.
REQ-007 SHALL have port RSTN_N  in  1  reset; one clock; reset is synchronous and active-high.
REQ-008 SHALL have port disp_valid  in  1  dispatch request.
REQ-009 SHALL have port disp_ready  out  1  free entry exists.
REQ-010 SHALL have port disp_op  in  2  00 add, 01 sub, 10 and, 11 xor.
REQ-011 SHALL have ports disp_tag1/disp_tag2  in  TAG_W  source producer tags (0 = value valid).
REQ-012 SHALL have ports disp_val1/disp_val2  in  DATA_W  source values, used when tag is 0.
REQ-013 SHALL have port disp_tag_o  out  TAG_W  tag assigned to the dispatching instruction.
REQ-014 SHALL have ports cdb_in_valid (1), cdb_in_tag (TAG_W), cdb_in_data (DATA_W)  in  broadcast bus.
REQ-015 SHALL have ports cdb_out_valid (out 1), cdb_out_ready (in 1), cdb_out_tag (out TAG_W), cdb_out_data (out DATA_W).
REQ-016 SHALL have port busy_count  out  TAG_W  number of occupied entries.

Function
REQ-017 disp_ready SHALL be 1 iff any entry is free in registered state; disp_tag_o SHALL be the lowest-index free entry's tag (0 when none free).
REQ-018 On disp_valid&&disp_ready the selected entry SHALL become busy next cycle, storing op, tags, values; disp_valid while !disp_ready SHALL be ignored.
REQ-019 If a dispatch source tag equals cdb_in_tag with cdb_in_valid in the same cycle, the entry SHALL capture cdb_in_data and store tag 0.
REQ-020 Each cycle, every busy entry with a source tag equal to valid cdb_in_tag SHALL latch cdb_in_data and clear that tag to 0; tag 0 on cdb_in SHALL be ignored.
REQ-021 An entry SHALL be ready when busy, not issued, both tags 0; at most one issue per cycle, lowest ready index wins.
REQ-022 Issued entry SHALL be marked issued and enter stage 1; result SHALL appear on cdb_out LAT cycles after issue absent stall.
REQ-023 Arithmetic SHALL be modulo 2^DATA_W (add/sub wrap, no flags).
REQ-024 cdb_out_valid/tag/data SHALL hold stable while cdb_out_valid&&!cdb_out_ready.
REQ-025 While the final stage is valid and !cdb_out_ready, the whole pipeline SHALL stall and no issue SHALL occur; bubbles SHALL NOT collapse.
REQ-026 An entry SHALL free only on the cdb_out handshake of its tag; freed entry SHALL be dispatchable from the following cycle, never the same cycle.
REQ-027 busy_count SHALL be registered and equal the occupied-entry count after each edge.
REQ-028 Simultaneous dispatch, wakeup, issue and free in one cycle SHALL all take effect, on distinct entries.

Reset
REQ-029 RSTN_N=1 at a rising edge SHALL free all entries, empty the pipeline, zero stored values.
REQ-030 After reset: disp_ready=1, disp_tag_o=TAG_BASE, cdb_out_valid=0, cdb_out_tag=0, cdb_out_data=0, busy_count=0.
REQ-031 Reset mid-operation SHALL discard all in-flight work; no result for a pre-reset dispatch SHALL appear.

Verification
REQ-032 Dispatch add 5+7, tags 0, ready=1 -> disp_tag_o=1; cdb_out tag 1 data 12 exactly 1+LAT cycles after dispatch edge.
REQ-033 Dispatch sub tag1=9 val2=3; 4 cycles later cdb_in tag 9 data 10 -> result tag 1 data 7; sub 0-1 -> 0xFFFFFFFF.
REQ-034 Dispatch 4 entries without free -> disp_ready=0, busy_count=4, 5th disp_valid ignored; after one handshake disp_ready=1 next cycle.
REQ-035 Hold cdb_out_ready=0 for 5 cycles with two results in flight -> output stable, no issue, both delivered in order once ready=1.
REQ-036 Dispatch with tag2 equal to same-cycle cdb_in tag 6 data 0x55 -> operand captured, entry issues next cycle.
REQ-037 Assert reset with 3 busy entries and pipeline full -> all outputs at REQ-030 values next cycle; no stale result thereafter.
